alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width (>=8, power of two).
REQ-002 SHALL have derived parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept request.
REQ-007 SHALL have port flag_ALUOp  input  6  opcode.
REQ-008 SHALL have ports data_1, data_2  input  WIDTH  operands.
REQ-009 SHALL have port shamt  input  SHW  shift amount.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port ALU_Result  output  WIDTH  registered result.
REQ-013 SHALL have port zero  output  1  high when ALU_Result == 1 (branch-taken flag).
REQ-014 SHALL have ports error_of, error_uf, error_div, error_op  output  1 each  registered error flags.

Function
REQ-015 SHALL implement FSM IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-016 SHALL capture opcode and operands on in_valid && in_ready; inputs ignored otherwise.
REQ-017 Opcodes 0x00-0x14 SHALL keep existing encodings: add, sub, mul, div, rem, and, or, xor, not, slt, slet, sgt, sget, beq, bne, bltz, blez, bgtz, bgez, srl, sll; set/branch ops signed, result 1/0.
REQ-018 New opcode 0x15 (sra) SHALL arithmetic-shift data_1 right by shamt.
REQ-019 Non-mul/div opcodes SHALL go IDLE->DONE; out_valid rises the cycle after acceptance (latency 1).
REQ-020 add: error_of=1 when operand signs equal and result sign differs; sub: error_uf=1 when operand signs differ and result sign differs from data_1.
REQ-021 mul SHALL be unsigned shift-add over full WIDTH operands in WIDTH cycles in MUL; ALU_Result = low WIDTH bits; error_of=1 when high WIDTH bits nonzero; latency WIDTH+1.
REQ-022 div/rem SHALL be unsigned restoring division over WIDTH cycles in DIV; latency WIDTH+1.
REQ-023 div/rem with data_2==0 SHALL skip DIV, go to DONE (latency 1), error_div=1, ALU_Result all-ones for div, data_1 for rem.
REQ-024 Undefined opcode SHALL complete in latency 1 with ALU_Result=0, error_op=1.
REQ-025 In DONE, ALU_Result, zero and error flags SHALL hold stable until out_valid && out_ready, then FSM returns to IDLE; no new acceptance in the same cycle.
REQ-026 Error flags not set by the current opcode SHALL be 0 in DONE.

Reset
REQ-027 rst SHALL, at any state including mid-MUL/DIV, force IDLE next cycle, abort iteration, and clear ALU_Result, error flags, out_valid to 0 (in_ready=1 after reset).
REQ-028 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-029 Macro ALU_MC_MULDIV_EN defined: mul/div/rem per REQ-021..023.
REQ-030 Macro ALU_MC_MULDIV_EN undefined: MUL/DIV states and iterative datapath absent; opcodes 0x02-0x04 treated per REQ-024.

Structure
REQ-031 Package alu_mc_pkg SHALL hold opcode constants (0x00-0x15) and the FSM state type.
REQ-032 Iterative mul/div datapath SHALL be sub-module alu_mc_iter (start, op, operands in; done, result, high-nonzero out).

Verification (WIDTH=32)
REQ-033 add 0x7FFFFFFF+1 -> out_valid 1 cycle after accept, ALU_Result 0x80000000, error_of=1.
REQ-034 mul 0x00010000*0x00010000 -> after 33 cycles ALU_Result 0, error_of=1; mul 7*6 -> 42, error_of=0.
REQ-035 div 100/7 -> 14 after 33 cycles; rem 100%7 -> 2; div 5/0 -> 1 cycle, 0xFFFFFFFF, error_div=1.
REQ-036 sra 0x80000000 shamt 4 -> 0xF8000000; slt -1,1 -> 1, zero=1; opcode 0x3F -> 0, error_op=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; assert rst at cycle 10 of div -> IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   - opcode constants (6-bit, 0x00..0x15)
//   - FSM state type for alu_mc
//   - operation select for the iterative mul/div unit
// Optional feature macro: ALU_MC_MULDIV_EN (adds MUL/DIV states).
package alu_mc_pkg;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_MUL  = 6'h02;
    localparam logic [5:0] OP_DIV  = 6'h03;
    localparam logic [5:0] OP_REM  = 6'h04;
    localparam logic [5:0] OP_AND  = 6'h05;
    localparam logic [5:0] OP_OR   = 6'h06;
    localparam logic [5:0] OP_XOR  = 6'h07;
    localparam logic [5:0] OP_NOT  = 6'h08;
    localparam logic [5:0] OP_SLT  = 6'h09;
    localparam logic [5:0] OP_SLET = 6'h0A;
    localparam logic [5:0] OP_SGT  = 6'h0B;
    localparam logic [5:0] OP_SGET = 6'h0C;
    localparam logic [5:0] OP_BEQ  = 6'h0D;
    localparam logic [5:0] OP_BNE  = 6'h0E;
    localparam logic [5:0] OP_BLTZ = 6'h0F;
    localparam logic [5:0] OP_BLEZ = 6'h10;
    localparam logic [5:0] OP_BGTZ = 6'h11;
    localparam logic [5:0] OP_BGEZ = 6'h12;
    localparam logic [5:0] OP_SRL  = 6'h13;
    localparam logic [5:0] OP_SLL  = 6'h14;
    localparam logic [5:0] OP_SRA  = 6'h15;

`ifdef ALU_MC_MULDIV_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} alu_state_t;
`else
    typedef enum logic {ST_IDLE, ST_DONE} alu_state_t;
`endif

    typedef enum logic [1:0] {ITER_MUL, ITER_DIV, ITER_REM} iter_op_t;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative unsigned multiplier / restoring divider.
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts iteration)
//   start         load operands and begin WIDTH iteration steps
//   op            ITER_MUL / ITER_DIV / ITER_REM (latched on start)
//   a, b          operands (multiplicand/multiplier, dividend/divisor)
//   done          high during the final step; result/hi_nz valid then
//   result        low product, quotient or remainder
//   hi_nz         high half of the product is nonzero
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  iter_op_t         op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hi_nz
);

    localparam int CW = $clog2(WIDTH);

    // hi/lo form one 2*WIDTH shift register shared by both algorithms:
    // mul: hi = partial product, lo = multiplier (shifted out LSB first)
    // div: hi = partial remainder, lo = dividend shifting into quotient
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] next_hi, next_lo;
    logic [WIDTH:0]   sum, trial;
    logic [CW-1:0]    cnt;
    logic             busy;
    iter_op_t         op_r;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        trial   = {hi, lo[WIDTH-1]} - {1'b0, opnd};
        next_hi = hi;
        next_lo = lo;
        if (op_r == ITER_MUL) begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], lo[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            next_hi = trial[WIDTH-1:0];
            next_lo = {lo[WIDTH-2:0], 1'b1};
        end else begin
            next_hi = {hi[WIDTH-2:0], lo[WIDTH-1]};
            next_lo = {lo[WIDTH-2:0], 1'b0};
        end
    end

    // Results come from the step's next values so the caller can finish
    // on the same edge as the last step.
    assign done   = busy && (cnt == CW'(WIDTH - 1));
    assign result = (op_r == ITER_REM) ? next_hi : next_lo;
    assign hi_nz  = |next_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
            op_r <= ITER_MUL;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            hi   <= '0;
            lo   <= (op == ITER_MUL) ? b : a;
            opnd <= (op == ITER_MUL) ? a : b;
            op_r <= op;
        end else if (busy) begin
            hi  <= next_hi;
            lo  <= next_lo;
            cnt <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       request handshake (ready only in IDLE)
//   flag_ALUOp                6-bit opcode (see alu_mc_pkg)
//   data_1, data_2, shamt     operands and shift amount
//   out_valid / out_ready     result handshake (valid only in DONE)
//   ALU_Result                registered result
//   zero                      high when ALU_Result == 1
//   error_of/uf/div/op        registered overflow/underflow/div0/bad-op
// Macro ALU_MC_MULDIV_EN enables mul/div/rem via alu_mc_iter; when
// undefined those opcodes complete as undefined operations.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       flag_ALUOp,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Result,
    output logic             zero,
    output logic             error_of,
    output logic             error_uf,
    output logic             error_div,
    output logic             error_op
);

    alu_state_t       state;
    logic [WIDTH-1:0] res_c;
    logic             of_c, uf_c, dz_c, eop_c;
    logic             go_mul, go_div;

`ifdef ALU_MC_MULDIV_EN
    iter_op_t         iter_op;
    logic             iter_done, iter_hi_nz;
    logic [WIDTH-1:0] iter_result;

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  ((state == ST_IDLE) && in_valid && (go_mul || go_div)),
        .op     (iter_op),
        .a      (data_1),
        .b      (data_2),
        .done   (iter_done),
        .result (iter_result),
        .hi_nz  (iter_hi_nz)
    );
`endif

    assign zero = (ALU_Result == WIDTH'(1));

    // Single-cycle results computed straight from the request inputs.
    always_comb begin
        res_c  = '0;
        of_c   = 1'b0;
        uf_c   = 1'b0;
        dz_c   = 1'b0;
        eop_c  = 1'b0;
        go_mul = 1'b0;
        go_div = 1'b0;
`ifdef ALU_MC_MULDIV_EN
        iter_op = ITER_MUL;
`endif
        case (flag_ALUOp)
            OP_ADD: begin
                res_c = data_1 + data_2;
                of_c  = (data_1[WIDTH-1] == data_2[WIDTH-1]) &&
                        (res_c[WIDTH-1] != data_1[WIDTH-1]);
            end
            OP_SUB: begin
                res_c = data_1 - data_2;
                uf_c  = (data_1[WIDTH-1] != data_2[WIDTH-1]) &&
                        (res_c[WIDTH-1] != data_1[WIDTH-1]);
            end
            OP_AND:  res_c = data_1 & data_2;
            OP_OR:   res_c = data_1 | data_2;
            OP_XOR:  res_c = data_1 ^ data_2;
            OP_NOT:  res_c = ~data_1;
            OP_SLT:  res_c = WIDTH'($signed(data_1) <  $signed(data_2));
            OP_SLET: res_c = WIDTH'($signed(data_1) <= $signed(data_2));
            OP_SGT:  res_c = WIDTH'($signed(data_1) >  $signed(data_2));
            OP_SGET: res_c = WIDTH'($signed(data_1) >= $signed(data_2));
            OP_BEQ:  res_c = WIDTH'(data_1 == data_2);
            OP_BNE:  res_c = WIDTH'(data_1 != data_2);
            OP_BLTZ: res_c = WIDTH'($signed(data_1) <  0);
            OP_BLEZ: res_c = WIDTH'($signed(data_1) <= 0);
            OP_BGTZ: res_c = WIDTH'($signed(data_1) >  0);
            OP_BGEZ: res_c = WIDTH'($signed(data_1) >= 0);
            OP_SRL:  res_c = data_1 >> shamt;
            OP_SLL:  res_c = data_1 << shamt;
            OP_SRA:  res_c = $unsigned($signed(data_1) >>> shamt);
`ifdef ALU_MC_MULDIV_EN
            OP_MUL: begin
                go_mul  = 1'b1;
                iter_op = ITER_MUL;
            end
            OP_DIV, OP_REM: begin
                if (data_2 == '0) begin
                    dz_c  = 1'b1;
                    res_c = (flag_ALUOp == OP_DIV) ? '1 : data_1;
                end else begin
                    go_div  = 1'b1;
                    iter_op = (flag_ALUOp == OP_DIV) ? ITER_DIV : ITER_REM;
                end
            end
`endif
            default: eop_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            ALU_Result <= '0;
            error_of   <= 1'b0;
            error_uf   <= 1'b0;
            error_div  <= 1'b0;
            error_op   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready   <= 1'b0;
                        ALU_Result <= res_c;
                        error_of   <= of_c;
                        error_uf   <= uf_c;
                        error_div  <= dz_c;
                        error_op   <= eop_c;
`ifdef ALU_MC_MULDIV_EN
                        if (go_mul)
                            state <= ST_MUL;
                        else if (go_div)
                            state <= ST_DIV;
                        else
`endif
                        begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
`ifdef ALU_MC_MULDIV_EN
                ST_MUL, ST_DIV: begin
                    if (iter_done) begin
                        ALU_Result <= iter_result;
                        error_of   <= (state == ST_MUL) && iter_hi_nz;
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=32).
// Expected values for mul/div/rem follow ALU_MC_MULDIV_EN.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  flag_ALUOp;
    logic [31:0] data_1, data_2;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALU_Result;
    logic        zero;
    logic        error_of, error_uf, error_div, error_op;

    int passed = 0;
    int total  = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flag_ALUOp (flag_ALUOp),
        .data_1     (data_1),
        .data_2     (data_2),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALU_Result (ALU_Result),
        .zero       (zero),
        .error_of   (error_of),
        .error_uf   (error_uf),
        .error_div  (error_div),
        .error_op   (error_op)
    );

    always #5 clk = ~clk;

    localparam int NV = 26;
    // flags column = {of, uf, div, op}
    logic [5:0]  v_op  [NV] = '{6'h00, 6'h00, 6'h01, 6'h01, 6'h05, 6'h06, 6'h07, 6'h08,
                                6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10,
                                6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h3F, 6'h16, 6'h01,
                                6'h00, 6'h15};
    logic [31:0] v_a   [NV] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'd10, 32'hF0F0F0F0,
                                32'h0F000000, 32'hFFFF0000, 32'h12345678, 32'hFFFFFFFF,
                                32'd5, 32'd1, 32'd2, 32'd9, 32'd9, 32'h80000000, 32'd0,
                                32'd0, 32'd0, 32'h80000000, 32'd1, 32'h80000000, 32'd77,
                                32'd77, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFF0};
    logic [31:0] v_b   [NV] = '{32'd1, 32'd3, 32'd1, 32'd3, 32'h0FF00FF0, 32'h000000F0,
                                32'h0F0F0F0F, 32'd0, 32'd1, 32'd5, 32'hFFFFFFFF, 32'd3,
                                32'd9, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                32'd0, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    logic [4:0]  v_sh  [NV] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                5'd4, 5'd31, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4};
    logic [31:0] v_res [NV] = '{32'h80000000, 32'd8, 32'h7FFFFFFF, 32'd7, 32'h00F000F0,
                                32'h0F0000F0, 32'hF0F00F0F, 32'hEDCBA987, 32'd1, 32'd1,
                                32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd1, 32'd0, 32'd1,
                                32'h08000000, 32'h80000000, 32'hF8000000, 32'd0, 32'd0,
                                32'h80000000, 32'd0, 32'h07FFFFFF};
    logic [3:0]  v_flg [NV] = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0100,
                                4'b1000, 4'b0000};

    // Drives one request from IDLE and returns cycles until out_valid
    // (1 = visible right after the accepting edge); gives up at 100.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int lat);
        flag_ALUOp = op;
        data_1     = a;
        data_2     = b;
        shamt      = sh;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flag_ALUOp = 6'h00;
        data_1 = '0;
        data_2 = '0;
        shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, ALU_Result, zero, error_of, error_uf, error_div, error_op}
            !== {1'b1, 1'b0, 32'd0, 1'b0, 4'b0000}) begin
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h z=%b flags=%b%b%b%b, want rdy=1 vld=0 res=0 z=0 flags=0000",
                     in_ready, out_valid, ALU_Result, zero, error_of, error_uf, error_div, error_op);
        end else passed++;
    endtask

    task automatic test_single_cycle_ops();
        int lat;
        for (int i = 0; i < NV; i++) begin
            issue(v_op[i], v_a[i], v_b[i], v_sh[i], lat);
            total++;
            if (lat !== 1) $display("FAIL vec%0d_latency: got %0d, want 1", i, lat);
            else passed++;
            total++;
            if (ALU_Result !== v_res[i])
                $display("FAIL vec%0d_result op=%h: got %h, want %h", i, v_op[i], ALU_Result, v_res[i]);
            else passed++;
            total++;
            if ({error_of, error_uf, error_div, error_op} !== v_flg[i])
                $display("FAIL vec%0d_flags: got %b%b%b%b, want %b", i,
                         error_of, error_uf, error_div, error_op, v_flg[i]);
            else passed++;
            total++;
            if (zero !== (v_res[i] == 32'd1))
                $display("FAIL vec%0d_zero: got %b, want %b", i, zero, (v_res[i] == 32'd1));
            else passed++;
            consume();
        end
    endtask

    task automatic test_mul();
        int lat;
`ifdef ALU_MC_MULDIV_EN
        localparam int LM = 33;
        localparam logic [31:0] R1 = 32'd0, R2 = 32'd42;
        localparam logic [3:0] F1 = 4'b1000, F2 = 4'b0000;
`else
        localparam int LM = 1;
        localparam logic [31:0] R1 = 32'd0, R2 = 32'd0;
        localparam logic [3:0] F1 = 4'b0001, F2 = 4'b0001;
`endif
        issue(6'h02, 32'h00010000, 32'h00010000, 5'd0, lat);
        total++;
        if (lat !== LM || ALU_Result !== R1 || {error_of, error_uf, error_div, error_op} !== F1)
            $display("FAIL mul_big: got lat=%0d res=%h flags=%b%b%b%b, want lat=%0d res=%h flags=%b",
                     lat, ALU_Result, error_of, error_uf, error_div, error_op, LM, R1, F1);
        else passed++;
        consume();
        issue(6'h02, 32'd7, 32'd6, 5'd0, lat);
        total++;
        if (lat !== LM || ALU_Result !== R2 || {error_of, error_uf, error_div, error_op} !== F2)
            $display("FAIL mul_7x6: got lat=%0d res=%h flags=%b%b%b%b, want lat=%0d res=%h flags=%b",
                     lat, ALU_Result, error_of, error_uf, error_div, error_op, LM, R2, F2);
        else passed++;
        consume();
    endtask

    task automatic test_div();
        int lat;
`ifdef ALU_MC_MULDIV_EN
        localparam int LD = 33;
        localparam logic [31:0] RQ = 32'd14, RR = 32'd2, RZ = 32'hFFFFFFFF, RZR = 32'd5;
        localparam logic [3:0] FN = 4'b0000, FZ = 4'b0010;
`else
        localparam int LD = 1;
        localparam logic [31:0] RQ = 32'd0, RR = 32'd0, RZ = 32'd0, RZR = 32'd0;
        localparam logic [3:0] FN = 4'b0001, FZ = 4'b0001;
`endif
        issue(6'h03, 32'd100, 32'd7, 5'd0, lat);
        total++;
        if (lat !== LD || ALU_Result !== RQ || {error_of, error_uf, error_div, error_op} !== FN)
            $display("FAIL div_100_7: got lat=%0d res=%h flags=%b%b%b%b, want lat=%0d res=%h flags=%b",
                     lat, ALU_Result, error_of, error_uf, error_div, error_op, LD, RQ, FN);
        else passed++;
        consume();
        issue(6'h04, 32'd100, 32'd7, 5'd0, lat);
        total++;
        if (lat !== LD || ALU_Result !== RR || {error_of, error_uf, error_div, error_op} !== FN)
            $display("FAIL rem_100_7: got lat=%0d res=%h flags=%b%b%b%b, want lat=%0d res=%h flags=%b",
                     lat, ALU_Result, error_of, error_uf, error_div, error_op, LD, RR, FN);
        else passed++;
        consume();
        issue(6'h03, 32'd5, 32'd0, 5'd0, lat);
        total++;
        if (lat !== 1 || ALU_Result !== RZ || {error_of, error_uf, error_div, error_op} !== FZ)
            $display("FAIL div_by_zero: got lat=%0d res=%h flags=%b%b%b%b, want lat=1 res=%h flags=%b",
                     lat, ALU_Result, error_of, error_uf, error_div, error_op, RZ, FZ);
        else passed++;
        consume();
        issue(6'h04, 32'd5, 32'd0, 5'd0, lat);
        total++;
        if (lat !== 1 || ALU_Result !== RZR || {error_of, error_uf, error_div, error_op} !== FZ)
            $display("FAIL rem_by_zero: got lat=%0d res=%h flags=%b%b%b%b, want lat=1 res=%h flags=%b",
                     lat, ALU_Result, error_of, error_uf, error_div, error_op, RZR, FZ);
        else passed++;
        consume();
    endtask

    task automatic test_hold();
        int lat;
        issue(6'h00, 32'h7FFFFFFF, 32'd1, 5'd0, lat);
        // A competing request during DONE must be ignored.
        flag_ALUOp = 6'h01;
        data_1 = 32'd3;
        data_2 = 32'd9;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if ({out_valid, in_ready, ALU_Result, error_of, error_uf} !== {1'b1, 1'b0, 32'h80000000, 2'b10})
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b res=%h of=%b uf=%b, want vld=1 rdy=0 res=80000000 of=1 uf=0",
                         c, out_valid, in_ready, ALU_Result, error_of, error_uf);
            else passed++;
        end
        // Handshake edge with in_valid still high: return to IDLE only.
        consume();
        total++;
        if ({out_valid, in_ready, ALU_Result} !== {1'b0, 1'b1, 32'h80000000})
            $display("FAIL release_no_accept: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=80000000",
                     out_valid, in_ready, ALU_Result);
        else passed++;
        // Still high: now accepted as sub 3-9 = 0xFFFFFFFA.
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if ({out_valid, ALU_Result, error_of} !== {1'b1, 32'hFFFFFFFA, 1'b0})
            $display("FAIL accept_after_release: got vld=%b res=%h of=%b, want vld=1 res=fffffffa of=0",
                     out_valid, ALU_Result, error_of);
        else passed++;
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        flag_ALUOp = 6'h03;
        data_1 = 32'd100;
        data_2 = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (9) @(posedge clk);
        #1;
        // Reset wins over a simultaneous request and release.
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid, ALU_Result, zero, error_of, error_uf, error_div, error_op}
            !== {1'b1, 1'b0, 32'd0, 1'b0, 4'b0000})
            $display("FAIL reset_mid_op: got rdy=%b vld=%b res=%h z=%b flags=%b%b%b%b, want rdy=1 vld=0 res=0 z=0 flags=0000",
                     in_ready, out_valid, ALU_Result, zero, error_of, error_uf, error_div, error_op);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_stays_idle: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        else passed++;
        issue(6'h03, 32'd100, 32'd7, 5'd0, lat);
        total++;
`ifdef ALU_MC_MULDIV_EN
        if (lat !== 33 || ALU_Result !== 32'd14)
            $display("FAIL div_after_reset: got lat=%0d res=%h, want lat=33 res=0000000e", lat, ALU_Result);
        else passed++;
`else
        if (lat !== 1 || error_op !== 1'b1)
            $display("FAIL div_after_reset: got lat=%0d op_err=%b, want lat=1 op_err=1", lat, error_op);
        else passed++;
`endif
        consume();
    endtask

    initial begin
        test_reset();
        test_single_cycle_ops();
        test_mul();
        test_div();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
